// File: rtl/vx_launch_pkg.sv
// Shared types for the Vortex launch controller: FSM state encoding and
// the outstanding-counter width helper.
package vx_launch_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RST_HOLD = 3'd1,
        RUN      = 3'd2,
        DRAIN    = 3'd3,
        DONE     = 3'd4
    } state_t;

    // Counter must hold 0..max_outstanding inclusive.
    function automatic int cnt_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/vx_launch_rd_tracker.sv
// Outstanding-read counter, valid-hold flag and memory-request gate between
// Vortex and memory.
module vx_launch_rd_tracker
    import vx_launch_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 64,
    parameter int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run_gate_i,
    input  logic             vx_req_valid_i,
    input  logic             vx_req_rw_i,
    output logic             vx_req_ready_o,
    output logic             mem_req_valid_o,
    input  logic             mem_req_ready_i,
    input  logic             mem_rsp_valid_i,
    input  logic             mem_rsp_ready_i,
    output logic             pending_o,
    output logic [CNT_W-1:0] outstanding_o
);

    // Handshake: a transfer fires on a cycle where valid && ready; once valid
    // has been shown to memory it stays up until that fire.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             at_limit, gate_open, rd_fire, rsp_fire;

    assign at_limit        = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign gate_open       = pending_q | (run_gate_i & ~(at_limit & ~vx_req_rw_i));
    assign mem_req_valid_o = gate_open & vx_req_valid_i;
    assign vx_req_ready_o  = gate_open & mem_req_ready_i;
    assign rd_fire         = mem_req_valid_o & mem_req_ready_i & ~vx_req_rw_i;
    assign rsp_fire        = mem_rsp_valid_i & mem_rsp_ready_i;

    always_comb begin
        pending_d = mem_req_valid_o & ~mem_req_ready_i;
        cnt_d     = cnt_q;
        if (rd_fire && !rsp_fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!rd_fire && rsp_fire && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o     = pending_q;
    assign outstanding_o = cnt_q;

    rsp_underflow_a : assert property (@(posedge clk) disable iff (!reset_n)
        !(rsp_fire && !rd_fire && cnt_q == '0))
        else $error("vx_launch_rd_tracker: response with no read outstanding");

endmodule

// File: rtl/vx_launch_ctrl.sv
// Run-control for a Vortex instance: holds it in reset, loads the start PC,
// runs it with a watchdog and drains outstanding reads before reporting done.
module vx_launch_ctrl
    import vx_launch_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int RESET_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES  = 0,
    parameter int MAX_OUTSTANDING = 64,
    parameter int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              abort,
    output logic              vx_reset,
    output logic [ADDR_W-1:0] vx_startup_addr,
    input  logic              vx_busy,
    input  logic              vx_mem_req_valid,
    input  logic              vx_mem_req_rw,
    output logic              vx_mem_req_ready,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic              mem_rsp_ready,
    output logic              running,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  outstanding,
    output state_t            dbg_state
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              timeout_q, timeout_d;
    logic              busy_seen_q, busy_seen_d;
    logic              vx_reset_q, running_q, done_q, run_gate_q;
    logic              pending;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        wdog_d      = wdog_q;
        addr_d      = addr_q;
        timeout_d   = timeout_q;
        busy_seen_d = busy_seen_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RST_HOLD;
                    addr_d      = start_pc;
                    hold_d      = HOLD_W'(RESET_CYCLES - 1);
                    wdog_d      = '0;
                    timeout_d   = 1'b0;
                    busy_seen_d = 1'b0;
                end
            end
            RST_HOLD: begin
                if (abort) begin
                    state_d = DONE;
                end else if (hold_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            RUN: begin
                busy_seen_d = busy_seen_q | vx_busy;
                wdog_d      = wdog_q + WD_W'(1);
                if (abort) begin
                    state_d = DRAIN;
                end else if (TIMEOUT_CYCLES != 0 && wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = DRAIN;
                    timeout_d = 1'b1;
                end else if (busy_seen_q && !vx_busy && outstanding == '0) begin
                    state_d = DONE;
                end
            end
            DRAIN: begin
                if (outstanding == '0 && !pending) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change with the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            wdog_q      <= '0;
            addr_q      <= '0;
            timeout_q   <= 1'b0;
            busy_seen_q <= 1'b0;
            vx_reset_q  <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            run_gate_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            wdog_q      <= wdog_d;
            addr_q      <= addr_d;
            timeout_q   <= timeout_d;
            busy_seen_q <= busy_seen_d;
            vx_reset_q  <= !(state_d == RUN || state_d == DRAIN);
            running_q   <= (state_d == RUN);
            done_q      <= (state_d == DONE);
            run_gate_q  <= (state_d == RUN);
        end
    end

    vx_launch_rd_tracker #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .CNT_W          (CNT_W)
    ) u_rd_tracker (
        .clk            (clk),
        .reset_n        (reset_n),
        .run_gate_i     (run_gate_q),
        .vx_req_valid_i (vx_mem_req_valid),
        .vx_req_rw_i    (vx_mem_req_rw),
        .vx_req_ready_o (vx_mem_req_ready),
        .mem_req_valid_o(mem_req_valid),
        .mem_req_ready_i(mem_req_ready),
        .mem_rsp_valid_i(mem_rsp_valid),
        .mem_rsp_ready_i(mem_rsp_ready),
        .pending_o      (pending),
        .outstanding_o  (outstanding)
    );

    assign vx_reset        = vx_reset_q;
    assign vx_startup_addr = addr_q;
    assign running         = running_q;
    assign done            = done_q;
    assign timeout         = timeout_q;
    assign dbg_state       = state_q;

endmodule

// File: doc/vx_launch_ctrl.md
Name: vx_launch_ctrl

Overview:
- Run-control and memory-gating controller in front of the Vortex top level.
- Holds the GPU in reset, loads the startup PC, releases reset, then monitors busy and outstanding memory reads.
- Gates the Vortex memory-request port during abort/timeout drain.
- Signals completion to the host-side shell.

Parameters:
ADDR_W, 32, width of startup PC
RESET_CYCLES, 8, cycles vx_reset is held asserted after start (>=1)
TIMEOUT_CYCLES, 0, RUN-state watchdog limit; 0 disables watchdog
MAX_OUTSTANDING, 64, max in-flight reads before new reads are blocked
CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding counter width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle launch pulse
start_pc  in  ADDR_W  startup address, sampled on accepted start
abort  in  1  level; request drain and stop
vx_reset  out  1  active-high reset to Vortex
vx_startup_addr  out  ADDR_W  registered startup address to Vortex
vx_busy  in  1  Vortex busy
vx_mem_req_valid  in  1  request valid from Vortex
vx_mem_req_rw  in  1  request type from Vortex (1 = write)
vx_mem_req_ready  out  1  ready back to Vortex
mem_req_valid  out  1  valid to memory
mem_req_ready  in  1  ready from memory
mem_rsp_valid  in  1  response valid (observed)
mem_rsp_ready  in  1  response ready (observed)
running  out  1  high in RUN
done  out  1  high in DONE
timeout  out  1  sticky; set when watchdog fires
outstanding  out  CNT_W  current in-flight read count

Behaviour:
- Reset (reset_n low, async):
  - state=IDLE, vx_reset=1, vx_startup_addr=0, outstanding=0.
  - timeout=0, busy_seen=0, pending=0.
  - All gates closed: mem_req_valid=0, vx_mem_req_ready=0.
- Gate open: mem_req_valid=vx_mem_req_valid and vx_mem_req_ready=mem_req_ready, both combinational.
- Gate closed: both outputs are 0.
- Valid-hold rule:
  - pending is set when mem_req_valid=1 && !mem_req_ready; it clears on fire.
  - While pending=1 the gate stays open regardless of state or limit, so a presented request is never withdrawn.
- Read limit: when outstanding==MAX_OUTSTANDING and vx_mem_req_rw==0, the gate is closed for that request (subject to pending). Writes are unaffected.
- Outstanding counter:
  - Increments on read fire (mem_req_valid && mem_req_ready && !rw).
  - Decrements on mem_rsp_valid && mem_rsp_ready.
  - Both in the same cycle: no change.
  - Decrement at 0 is a simulation assertion error; the counter holds at 0.
- FSM:
  - IDLE: vx_reset=1, gate closed. On start: latch start_pc into vx_startup_addr, load hold counter with RESET_CYCLES-1, go to RST_HOLD.
  - RST_HOLD: vx_reset=1, gate closed. Counter decrements; at 0 go to RUN next cycle. vx_reset is therefore high for exactly RESET_CYCLES cycles after the start cycle. abort goes to DONE.
  - RUN: vx_reset=0, gate open, running=1.
    - busy_seen is set on any cycle with vx_busy=1.
    - Watchdog counts up from 0.
    - Exits, highest priority first:
      - abort goes to DRAIN.
      - Watchdog == TIMEOUT_CYCLES-1 (when TIMEOUT_CYCLES != 0) sets timeout and goes to DRAIN.
      - busy_seen && !vx_busy && outstanding==0 goes to DONE.
  - DRAIN: vx_reset=0, gate closed except for pending. When outstanding==0 && pending==0, go to DONE.
  - DONE: vx_reset=1, done=1, gate closed. On start: same as the IDLE start path; clear timeout, busy_seen and the watchdog.
- start is ignored outside IDLE and DONE.
- abort is ignored in IDLE and DONE.
- start and abort in the same cycle in IDLE/DONE: start wins.
- Latency: start to vx_reset deassert is RESET_CYCLES+1 cycles.

Decomposition:
- Shared package vx_launch_pkg holds:
  - state enum (IDLE, RST_HOLD, RUN, DRAIN, DONE), 3-bit encoding;
  - CNT_W computation function.
- Sub-module vx_launch_rd_tracker contains the outstanding counter, the pending flag and the gate-enable logic.
- The FSM and watchdog stay in the top module.

Test Plan:
- Launch: start=1, start_pc=0x8000_0000 → vx_reset high 8 cycles after start, low from cycle 9; vx_startup_addr=0x8000_0000; running=1.
- Normal finish: in RUN, vx_busy high 20 cycles, 3 reads fire and 3 responses return, then busy low → done=1 one cycle later; vx_reset=1; outstanding=0.
- Abort with 2 reads in flight and a stalled request (valid=1, ready=0) → request stays presented until fire; no new reads pass; DRAIN until outstanding=0, then DONE.
- Limit: MAX_OUTSTANDING=4, issue 5 reads with no responses → 5th blocked (vx_mem_req_ready=0); a write passes; one response releases the 5th read.
- Watchdog: TIMEOUT_CYCLES=100, busy stuck high → timeout=1 at RUN cycle 100, DRAIN, then DONE; timeout is cleared by the next start.
- Async reset: reset_n low mid-RUN with outstanding=3 → same cycle state=IDLE, vx_reset=1, outstanding=0, gates closed.
